// File: rtl/gray_rx_tracker.sv
// Gray-code receive tracker: two-stage pipeline with Gray-to-binary conversion, step classification and a lock FSM.
// Optional saturating error counter is built when GRAY_RX_ERR_CNT_EN is defined; otherwise err_count is tied to zero.
module gray_rx_tracker #(
  parameter int N         = 4,
  parameter int ERR_CNT_W = 8,
  parameter int LOCK_CNT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         gray_in,
  input  logic                 in_valid,
  output logic [N-1:0]         bin_out,
  output logic                 bin_valid,
  output logic                 dir_up,
  output logic                 dir_down,
  output logic                 step_err,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  state_t       state, state_nxt;
  logic [3:0]   good_cnt, good_cnt_nxt;

  logic [N-1:0] s1_gray;
  logic         s1_valid;
  logic [N-1:0] prev_gray;
  logic [N-1:0] bin_new;
  logic [N-1:0] gray_delta;
  logic [N-1:0] bin_step;
  logic         is_hold;
  logic         is_single;
  logic         classify;
  logic         up_c;
  logic         down_c;
  logic         err_c;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bin_new[i] = ^(s1_gray >> i);
    end
  end

  // The first sample after reset has no predecessor and is never classified.
  assign classify   = s1_valid && (state != IDLE);
  assign gray_delta = s1_gray ^ prev_gray;
  assign is_hold    = (gray_delta == '0);
  assign is_single  = !is_hold && ((gray_delta & (gray_delta - 1'b1)) == '0);
  assign bin_step   = bin_new - bin_out;
  assign up_c       = classify && is_single && (bin_step == N'(1));
  assign down_c     = classify && is_single && (bin_step == '1);
  assign err_c      = classify && !is_hold && !is_single;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_gray   <= '0;
      prev_gray <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      dir_up    <= 1'b0;
      dir_down  <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      if (in_valid) s1_gray <= gray_in;
      bin_valid <= s1_valid;
      dir_up    <= up_c;
      dir_down  <= down_c;
      step_err  <= err_c;
      if (s1_valid) begin
        prev_gray <= s1_gray;
        bin_out   <= bin_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred on untaken paths.
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    if (s1_valid) begin
      case (state)
        IDLE: begin
          state_nxt    = ACQ;
          good_cnt_nxt = '0;
        end
        ACQ: begin
          if (err_c) begin
            good_cnt_nxt = '0;
          end else if (is_single) begin
            if (good_cnt + 4'd1 == 4'(LOCK_CNT)) begin
              state_nxt    = LOCK;
              good_cnt_nxt = '0;
            end else begin
              good_cnt_nxt = good_cnt + 4'd1;
            end
          end
        end
        LOCK: begin
          if (err_c) begin
            state_nxt    = ACQ;
            good_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = IDLE;
          good_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCK);
  end

`ifdef GRAY_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_c && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_gray_rx_tracker.sv
// Scoreboard bench for gray_rx_tracker: a reference model queues expected outputs as samples are driven.
// A second instance with ERR_CNT_W = 2 exercises err_count saturation.
module tb_gray_rx_tracker;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [N-1:0] gray_in = '0;

  logic [N-1:0] bin_out, s_bin_out;
  logic         bin_valid, dir_up, dir_down, step_err, locked;
  logic         s_bin_valid, s_dir_up, s_dir_down, s_step_err, s_locked;
  logic [7:0]   err_count;
  logic [1:0]   s_err_count;

  gray_rx_tracker #(.N(N), .ERR_CNT_W(8), .LOCK_CNT(3)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid),
    .bin_out(bin_out), .bin_valid(bin_valid), .dir_up(dir_up), .dir_down(dir_down),
    .step_err(step_err), .locked(locked), .err_count(err_count)
  );

  gray_rx_tracker #(.N(N), .ERR_CNT_W(2), .LOCK_CNT(3)) u_sat (
    .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid),
    .bin_out(s_bin_out), .bin_valid(s_bin_valid), .dir_up(s_dir_up), .dir_down(s_dir_down),
    .step_err(s_step_err), .locked(s_locked), .err_count(s_err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] bin;
    logic       up;
    logic       dn;
    logic       err;
    logic       lck;
    logic [7:0] ec;
    logic [1:0] ec2;
  } exp_t;

  typedef struct {
    exp_t e;
    int   due;
  } sb_t;

  sb_t sb[$];
  int  cyc    = 0;
  int  checks = 0;
  int  passes = 0;

  // Reference model state: 0 idle, 1 acquiring, 2 locked.
  int         m_state;
  int         m_cnt;
  int         m_err8;
  int         m_err2;
  logic [3:0] m_prev_gray;
  logic [3:0] m_prev_bin;

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic model_reset();
    m_state     = 0;
    m_cnt       = 0;
    m_err8      = 0;
    m_err2      = 0;
    m_prev_gray = '0;
    m_prev_bin  = '0;
  endtask

  // Drive one valid sample at the current (negedge) time and queue its expected result.
  task automatic drive(input logic [3:0] g);
    exp_t       e;
    sb_t        item;
    logic [3:0] b, nxt_up, nxt_dn;
    int         hd;
    rst      = 1'b0;
    in_valid = 1'b1;
    gray_in  = g;
    b        = g2b(g);
    nxt_up   = m_prev_bin + 4'd1;
    nxt_dn   = m_prev_bin - 4'd1;
    e        = '0;
    if (m_state == 0) begin
      m_state = 1;
      m_cnt   = 0;
    end else begin
      hd = $countones(g ^ m_prev_gray);
      if (hd == 1) begin
        e.up = (b == nxt_up);
        e.dn = (b == nxt_dn);
        if (m_state == 1) begin
          m_cnt++;
          if (m_cnt == 3) begin
            m_state = 2;
            m_cnt   = 0;
          end
        end
      end else if (hd > 1) begin
        e.err   = 1'b1;
        m_err8  = (m_err8 < 255) ? m_err8 + 1 : 255;
        m_err2  = (m_err2 < 3) ? m_err2 + 1 : 3;
        m_cnt   = 0;
        m_state = 1;
      end
    end
    m_prev_gray = g;
    m_prev_bin  = b;
    e.bin = b;
    e.lck = (m_state == 2);
`ifdef GRAY_RX_ERR_CNT_EN
    e.ec  = 8'(m_err8);
    e.ec2 = 2'(m_err2);
`endif
    item.e   = e;
    item.due = cyc + 2;
    sb.push_back(item);
  endtask

  task automatic send(input logic [3:0] g);
    @(negedge clk);
    drive(g);
  endtask

  // Hold rst for n cycles with random valid samples; caller is already at a negedge.
  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      gray_in  = 4'($urandom_range(15));
      if (i == 0) begin
        while (sb.size() > 0 && sb[$].due >= cyc + 1) void'(sb.pop_back());
        model_reset();
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_cycles(2);
    idle_cycles(1);
  endtask

  // Scoreboard monitor: samples 1 time unit after each rising edge.
  sb_t  mon_item;
  exp_t mon_got;
  logic [5:0] mon_exp2, mon_got2;
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      $display("FAIL missed_output: due cycle %0d, still pending at cycle %0d", sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_item = sb.pop_front();
      mon_got  = {bin_out, dir_up, dir_down, step_err, locked, err_count, s_err_count};
      mon_got2 = {s_bin_out, s_dir_up, s_dir_down, s_step_err, s_locked, s_bin_valid};
      mon_exp2 = {mon_item.e.bin, mon_item.e.up, mon_item.e.dn, mon_item.e.err, mon_item.e.lck, 1'b1};
      checks++;
      if (bin_valid !== 1'b1 || mon_got !== mon_item.e || mon_got2 !== mon_exp2)
        $display("FAIL sample@%0d: got valid=%b bin=%0d up=%b dn=%b err=%b lck=%b ec=%0d ec2=%0d sat=%b, want valid=1 bin=%0d up=%b dn=%b err=%b lck=%b ec=%0d ec2=%0d sat=%b",
                 cyc, bin_valid, bin_out, dir_up, dir_down, step_err, locked, err_count, s_err_count, mon_got2,
                 mon_item.e.bin, mon_item.e.up, mon_item.e.dn, mon_item.e.err, mon_item.e.lck,
                 mon_item.e.ec, mon_item.e.ec2, mon_exp2);
      else passes++;
    end else begin
      checks++;
      if ({bin_valid, dir_up, dir_down, step_err, s_bin_valid} !== 5'b0)
        $display("FAIL idle_pulses@%0d: valid/up/dn/err/sat_valid=%b, want 00000", cyc,
                 {bin_valid, dir_up, dir_down, step_err, s_bin_valid});
      else passes++;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    rst_cycles(10);
    idle_cycles(1);
    @(negedge clk);
    checks++;
    if ({bin_out, bin_valid, dir_up, dir_down, step_err} !== 8'b0)
      $display("FAIL reset_outputs: bin=%0d valid=%b up=%b dn=%b err=%b, want all 0",
               bin_out, bin_valid, dir_up, dir_down, step_err);
    else passes++;
    checks++;
    if (locked !== 1'b0 || s_locked !== 1'b0)
      $display("FAIL reset_locked: locked=%b sat_locked=%b, want 0", locked, s_locked);
    else passes++;
    checks++;
    if (err_count !== 8'd0 || s_err_count !== 2'd0)
      $display("FAIL reset_err_count: err_count=%0d sat=%0d, want 0", err_count, s_err_count);
    else passes++;
  endtask

  task automatic test_up_count();
    send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0010); send(4'b0110);
    idle_cycles(4);
    checks++;
    if (bin_out !== 4'd4 || locked !== 1'b1)
      $display("FAIL up_count_end: bin=%0d locked=%b, want bin=4 locked=1", bin_out, locked);
    else passes++;
  endtask

  task automatic test_wrap();
    reset_dut();
    send(4'b1001); send(4'b1000); send(4'b0000); send(4'b1000);
    idle_cycles(4);
    checks++;
    if (bin_out !== 4'd15 || locked !== 1'b1)
      $display("FAIL wrap_end: bin=%0d locked=%b, want bin=15 locked=1", bin_out, locked);
    else passes++;
  endtask

  task automatic test_illegal_jump();
    reset_dut();
    send(4'b0110); send(4'b0010); send(4'b0011); send(4'b0001);
    send(4'b0010);
    send(4'b0110); send(4'b0111); send(4'b0101);
    idle_cycles(4);
    checks++;
    if (bin_out !== 4'd6 || locked !== 1'b1)
      $display("FAIL relock_end: bin=%0d locked=%b, want bin=6 locked=1", bin_out, locked);
    else passes++;
  endtask

  task automatic test_saturation();
    logic [7:0] want8;
    logic [1:0] want2;
    reset_dut();
    send(4'b0000);
    for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 4'b0011 : 4'b0000);
    idle_cycles(4);
`ifdef GRAY_RX_ERR_CNT_EN
    want8 = 8'd5;
    want2 = 2'd3;
`else
    want8 = 8'd0;
    want2 = 2'd0;
`endif
    checks++;
    if (err_count !== want8 || s_err_count !== want2)
      $display("FAIL saturation_end: err_count=%0d sat=%0d, want %0d and %0d", err_count, s_err_count, want8, want2);
    else passes++;
  endtask

  task automatic test_mid_reset();
    reset_dut();
    send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0010); send(4'b0110);
    @(negedge clk);
    checks++;
    if (locked !== 1'b1)
      $display("FAIL mid_reset_pre_lock: locked=%b, want 1", locked);
    else passes++;
    rst_cycles(1);
    @(negedge clk);
    checks++;
    if ({bin_out, bin_valid, dir_up, dir_down, step_err, locked, err_count} !== 17'b0)
      $display("FAIL mid_reset_outputs: bin=%0d valid=%b up=%b dn=%b err=%b locked=%b ec=%0d, want all 0",
               bin_out, bin_valid, dir_up, dir_down, step_err, locked, err_count);
    else passes++;
    drive(4'b0111);
    idle_cycles(4);
    checks++;
    if (bin_out !== 4'd5 || locked !== 1'b0)
      $display("FAIL mid_reset_first: bin=%0d locked=%b, want bin=5 locked=0", bin_out, locked);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] g;
    int         kind;
    reset_dut();
    g = 4'($urandom_range(15));
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(9);
      if (kind < 6)      g = g ^ (4'd1 << $urandom_range(3));
      else if (kind < 8) g = 4'($urandom_range(15));
      send(g);
    end
    idle_cycles(4);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_count();
    test_wrap();
    test_illegal_jump();
    test_saturation();
    test_mid_reset();
    test_back_to_back();
    checks++;
    if (sb.size() !== 0)
      $display("FAIL scoreboard_leftover: %0d entries, want 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
